// File: rtl/ram_pkg.sv
// rtl/ram_pkg.sv - shared types and constants for the byte-enable dual-port RAM
package ram_pkg;

  typedef enum logic {
    RDW_READ_FIRST  = 1'b0,
    RDW_WRITE_FIRST = 1'b1
  } rdw_mode_e;

  typedef enum logic {
    CLR_IDLE  = 1'b0,
    CLR_CLEAR = 1'b1
  } clr_state_e;

  localparam int BYTE_WIDTH = 8;

endpackage

// File: rtl/ram_clear_fsm.sv
// rtl/ram_clear_fsm.sv - sequencer that zeroes every word of the RAM, one word per cycle
module ram_clear_fsm
  import ram_pkg::*;
#(
  parameter int ADDRESS_WIDTH  = 8,
  parameter int DEPTH          = 1 << ADDRESS_WIDTH,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clear_request,
  output logic                     busy,
  output logic                     clear_write,
  output logic [ADDRESS_WIDTH-1:0] clear_address
);

  localparam clr_state_e RESET_STATE = CLEAR_ON_RESET ? CLR_CLEAR : CLR_IDLE;
  localparam logic [ADDRESS_WIDTH-1:0] LAST_ADDRESS = ADDRESS_WIDTH'(DEPTH - 1);

  clr_state_e               state;
  clr_state_e               state_next;
  logic [ADDRESS_WIDTH-1:0] count;
  logic                     last;

  assign last = (count == LAST_ADDRESS);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= RESET_STATE;
      count <= '0;
    end else begin
      state <= state_next;
      if (state == CLR_CLEAR) begin
        count <= last ? '0 : count + 1'b1;
      end
    end
  end

  // Requests arriving while already clearing are ignored, so a clear never stretches.
  always_comb begin
    state_next = state;
    case (state)
      CLR_IDLE:  if (clear_request) state_next = CLR_CLEAR;
      CLR_CLEAR: if (last) state_next = CLR_IDLE;
      default:   state_next = RESET_STATE;
    endcase
  end

  always_comb begin
    busy          = (state == CLR_CLEAR);
    clear_write   = (state == CLR_CLEAR);
    clear_address = count;
  end

endmodule

// File: rtl/ram_dual_port_be.sv
// rtl/ram_dual_port_be.sv - simple dual-port RAM with byte enables, 1/2-cycle read latency and clear engine
module ram_dual_port_be
  import ram_pkg::*;
#(
  parameter int DATA_WIDTH     = 16,
  parameter int ADDRESS_WIDTH  = 8,
  parameter int DEPTH          = 1 << ADDRESS_WIDTH,
  parameter int READ_LATENCY   = 1,
  parameter int RDW_MODE       = 0,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                           Clock,
  input  logic                           Reset,
  input  logic [ADDRESS_WIDTH-1:0]       write_address,
  input  logic                           Write_Enable,
  input  logic [DATA_WIDTH/BYTE_WIDTH-1:0] Byte_Enable,
  input  logic [DATA_WIDTH-1:0]          DATA_WRITE,
  input  logic [ADDRESS_WIDTH-1:0]       read_address,
  input  logic                           Read_Enable,
  output logic [DATA_WIDTH-1:0]          DATA_READ,
  output logic                           Read_Valid,
  input  logic                           Clear_Request,
  output logic                           Clear_Busy
);

  localparam int BYTES = DATA_WIDTH / BYTE_WIDTH;
  localparam bit WRITE_FIRST = (RDW_MODE == int'(RDW_WRITE_FIRST));
  localparam logic [ADDRESS_WIDTH:0] DEPTH_LIMIT = (ADDRESS_WIDTH + 1)'(DEPTH);

  logic [DATA_WIDTH-1:0]    mem [DEPTH];
  logic                     clear_write;
  logic [ADDRESS_WIDTH-1:0] clear_address;
  logic                     write_in_range;
  logic                     read_in_range;
  logic                     user_write;
  logic                     read_accept;
  logic [DATA_WIDTH-1:0]    stored_word;
  logic [DATA_WIDTH-1:0]    read_word;

  ram_clear_fsm #(
    .ADDRESS_WIDTH (ADDRESS_WIDTH),
    .DEPTH         (DEPTH),
    .CLEAR_ON_RESET(CLEAR_ON_RESET != 0)
  ) u_clear_fsm (
    .clk          (Clock),
    .rst          (Reset),
    .clear_request(Clear_Request),
    .busy         (Clear_Busy),
    .clear_write  (clear_write),
    .clear_address(clear_address)
  );

  assign write_in_range = ({1'b0, write_address} < DEPTH_LIMIT);
  assign read_in_range  = ({1'b0, read_address} < DEPTH_LIMIT);
  assign user_write     = Write_Enable && !Clear_Busy && write_in_range && (Byte_Enable != '0);
  assign read_accept    = Read_Enable && !Clear_Busy;

  // The clear engine owns the write port while busy; user writes are gated off above.
  always_ff @(posedge Clock) begin
    if (clear_write) begin
      mem[clear_address] <= '0;
    end else if (user_write) begin
      for (int i = 0; i < BYTES; i++) begin
        if (Byte_Enable[i]) begin
          mem[write_address][i*BYTE_WIDTH +: BYTE_WIDTH] <= DATA_WRITE[i*BYTE_WIDTH +: BYTE_WIDTH];
        end
      end
    end
  end

  assign stored_word = read_in_range ? mem[read_address] : '0;

  // Write-first forwards the enabled bytes of a colliding write into the read result.
  always_comb begin
    read_word = stored_word;
    if (WRITE_FIRST && user_write && (write_address == read_address)) begin
      for (int i = 0; i < BYTES; i++) begin
        if (Byte_Enable[i]) begin
          read_word[i*BYTE_WIDTH +: BYTE_WIDTH] = DATA_WRITE[i*BYTE_WIDTH +: BYTE_WIDTH];
        end
      end
    end
  end

  generate
    if (READ_LATENCY == 2) begin : g_latency_2
      logic                  stage_valid;
      logic [DATA_WIDTH-1:0] stage_data;

      always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
          stage_valid <= 1'b0;
          stage_data  <= '0;
          Read_Valid  <= 1'b0;
          DATA_READ   <= '0;
        end else begin
          stage_valid <= read_accept;
          if (read_accept) begin
            stage_data <= read_word;
          end
          Read_Valid <= stage_valid;
          if (stage_valid) begin
            DATA_READ <= stage_data;
          end
        end
      end
    end else begin : g_latency_1
      always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
          Read_Valid <= 1'b0;
          DATA_READ  <= '0;
        end else begin
          Read_Valid <= read_accept;
          if (read_accept) begin
            DATA_READ <= read_word;
          end
        end
      end
    end
  endgenerate

endmodule

// File: tb/tb_ram_dual_port_be.sv
// tb/tb_ram_dual_port_be.sv - directed vector bench for ram_dual_port_be (two configurations side by side)
module tb_ram_dual_port_be;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  waddr;
  logic [7:0]  raddr;
  logic        we;
  logic        re;
  logic        creq;
  logic [1:0]  be;
  logic [15:0] wdata;
  logic [15:0] dr_a;
  logic [15:0] dr_b;
  logic        rv_a;
  logic        rv_b;
  logic        busy_a;
  logic        busy_b;

  int checks = 0;
  int passed = 0;

  typedef struct {
    logic        we;
    logic [1:0]  be;
    logic [7:0]  waddr;
    logic [15:0] wdata;
    logic        re;
    logic [7:0]  raddr;
    logic [15:0] exp_a;
    logic [15:0] exp_b;
  } vec_t;

  vec_t vecs [13];

  always #5 clk = ~clk;

  // a: full depth, latency 1, read-first
  ram_dual_port_be #(
    .DATA_WIDTH(16), .ADDRESS_WIDTH(8), .DEPTH(256),
    .READ_LATENCY(1), .RDW_MODE(0), .CLEAR_ON_RESET(1)
  ) u_a (
    .Clock(clk), .Reset(rst),
    .write_address(waddr), .Write_Enable(we), .Byte_Enable(be), .DATA_WRITE(wdata),
    .read_address(raddr), .Read_Enable(re),
    .DATA_READ(dr_a), .Read_Valid(rv_a),
    .Clear_Request(creq), .Clear_Busy(busy_a)
  );

  // b: 192 words, latency 2, write-first
  ram_dual_port_be #(
    .DATA_WIDTH(16), .ADDRESS_WIDTH(8), .DEPTH(192),
    .READ_LATENCY(2), .RDW_MODE(1), .CLEAR_ON_RESET(1)
  ) u_b (
    .Clock(clk), .Reset(rst),
    .write_address(waddr), .Write_Enable(we), .Byte_Enable(be), .DATA_WRITE(wdata),
    .read_address(raddr), .Read_Enable(re),
    .DATA_READ(dr_b), .Read_Valid(rv_b),
    .Clear_Request(creq), .Clear_Busy(busy_b)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    we = 1'b0; re = 1'b0; creq = 1'b0; be = 2'b00;
    wdata = 16'h0; waddr = 8'h0; raddr = 8'h0;
  endtask

  task automatic write_word(input logic [7:0] a, input logic [15:0] d);
    we = 1'b1; be = 2'b11; waddr = a; wdata = d;
    tick;
    idle;
  endtask

  task automatic read_check(input string name, input logic [7:0] a, input logic [15:0] ea, input logic [15:0] eb);
    re = 1'b1; raddr = a;
    tick;
    idle;
    check({name, " a_valid"}, rv_a, 1);
    check({name, " a_data"}, dr_a, ea);
    tick;
    check({name, " b_valid"}, rv_b, 1);
    check({name, " b_data"}, dr_b, eb);
  endtask

  // Counts edges until each instance drops Clear_Busy; optionally hammers the ports meanwhile.
  task automatic measure_clear(input string tag, input bit disturb);
    int na = 0;
    int nb = 0;
    int pulses = 0;
    for (int n = 1; n <= 400 && (na == 0 || nb == 0); n++) begin
      idle;
      if (disturb && n <= 150) begin
        we = 1'b1; be = 2'b11; waddr = 8'd30; wdata = 16'hFFFF;
        re = 1'b1; raddr = 8'd5;
        creq = (n == 100);
      end
      tick;
      if (rv_a) pulses++;
      if (rv_b) pulses++;
      if (na == 0 && !busy_a) na = n;
      if (nb == 0 && !busy_b) nb = n;
    end
    idle;
    check({tag, " busy_len_a"}, na, 256);
    check({tag, " busy_len_b"}, nb, 192);
    check({tag, " valid_during_clear"}, pulses, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vecs[0]  = '{1'b1, 2'b11, 8'h05, 16'hABCD, 1'b0, 8'h00, 16'h0000, 16'h0000};
    vecs[1]  = '{1'b1, 2'b01, 8'h05, 16'h1234, 1'b0, 8'h00, 16'h0000, 16'h0000};
    vecs[2]  = '{1'b0, 2'b00, 8'h00, 16'h0000, 1'b1, 8'h05, 16'hAB34, 16'hAB34};
    vecs[3]  = '{1'b1, 2'b11, 8'h09, 16'h1111, 1'b0, 8'h00, 16'h0000, 16'h0000};
    vecs[4]  = '{1'b1, 2'b11, 8'h09, 16'h5555, 1'b1, 8'h09, 16'h1111, 16'h5555};
    vecs[5]  = '{1'b0, 2'b00, 8'h00, 16'h0000, 1'b1, 8'h09, 16'h5555, 16'h5555};
    vecs[6]  = '{1'b1, 2'b10, 8'h0A, 16'hBEEF, 1'b1, 8'h0A, 16'h0000, 16'hBE00};
    vecs[7]  = '{1'b1, 2'b11, 8'hC8, 16'h7777, 1'b1, 8'hC8, 16'h0000, 16'h0000};
    vecs[8]  = '{1'b0, 2'b00, 8'h00, 16'h0000, 1'b1, 8'hC8, 16'h7777, 16'h0000};
    vecs[9]  = '{1'b1, 2'b00, 8'h03, 16'hAAAA, 1'b1, 8'h03, 16'h0000, 16'h0000};
    vecs[10] = '{1'b0, 2'b00, 8'h00, 16'h0000, 1'b1, 8'h7F, 16'h0000, 16'h0000};
    vecs[11] = '{1'b1, 2'b11, 8'h14, 16'h1357, 1'b1, 8'h15, 16'h0000, 16'h0000};
    vecs[12] = '{1'b0, 2'b00, 8'h00, 16'h0000, 1'b1, 8'h14, 16'h1357, 16'h1357};

    idle;
    rst = 1'b1;
    tick;
    tick;
    check("reset a_data", dr_a, 0);
    check("reset b_data", dr_b, 0);
    check("reset a_valid", rv_a, 0);
    check("reset b_valid", rv_b, 0);
    check("reset a_busy", busy_a, 1);
    check("reset b_busy", busy_b, 1);
    rst = 1'b0;
    measure_clear("power-on", 1'b0);

    for (int i = 0; i < 13; i++) begin
      we = vecs[i].we; be = vecs[i].be; waddr = vecs[i].waddr; wdata = vecs[i].wdata;
      re = vecs[i].re; raddr = vecs[i].raddr;
      tick;
      idle;
      check($sformatf("v%0d a_valid", i), rv_a, vecs[i].re);
      check($sformatf("v%0d b_valid_early", i), rv_b, 0);
      if (vecs[i].re) check($sformatf("v%0d a_data", i), dr_a, vecs[i].exp_a);
      tick;
      check($sformatf("v%0d a_valid_after", i), rv_a, 0);
      check($sformatf("v%0d b_valid", i), rv_b, vecs[i].re);
      if (vecs[i].re) check($sformatf("v%0d b_data", i), dr_b, vecs[i].exp_b);
    end

    tick;
    tick;
    check("hold a_data", dr_a, 16'h1357);
    check("hold b_data", dr_b, 16'h1357);

    for (int i = 0; i < 4; i++) write_word(8'(i), 16'hA0B0 + 16'(i));
    for (int i = 0; i < 4; i++) begin
      re = 1'b1; raddr = 8'(i);
      tick;
      check($sformatf("b2b%0d a_valid", i), rv_a, 1);
      check($sformatf("b2b%0d a_data", i), dr_a, 16'hA0B0 + 16'(i));
      if (i > 0) begin
        check($sformatf("b2b%0d b_valid", i), rv_b, 1);
        check($sformatf("b2b%0d b_data", i), dr_b, 16'hA0B0 + 16'(i - 1));
      end
    end
    idle;
    tick;
    check("b2b a_valid_end", rv_a, 0);
    check("b2b b_valid_last", rv_b, 1);
    check("b2b b_data_last", dr_b, 16'hA0B3);
    tick;
    check("b2b b_valid_end", rv_b, 0);

    creq = 1'b1;
    tick;
    creq = 1'b0;
    check("req a_busy", busy_a, 1);
    check("req b_busy", busy_b, 1);
    measure_clear("request", 1'b1);
    read_check("clr addr5", 8'd5, 16'h0000, 16'h0000);
    read_check("clr addr9", 8'd9, 16'h0000, 16'h0000);
    read_check("clr addr20", 8'd20, 16'h0000, 16'h0000);
    read_check("clr addr30", 8'd30, 16'h0000, 16'h0000);
    read_check("clr addr200", 8'd200, 16'h0000, 16'h0000);

    write_word(8'd40, 16'h2468);
    read_check("pre-abort addr40", 8'd40, 16'h2468, 16'h2468);
    creq = 1'b1;
    tick;
    creq = 1'b0;
    for (int n = 0; n < 100; n++) tick;
    check("abort a_busy_mid", busy_a, 1);
    check("abort a_hold", dr_a, 16'h2468);
    check("abort b_hold", dr_b, 16'h2468);
    #2;
    rst = 1'b1;
    #1;
    check("abort a_data_async", dr_a, 0);
    check("abort b_data_async", dr_b, 0);
    check("abort a_valid_async", rv_a, 0);
    check("abort b_valid_async", rv_b, 0);
    tick;
    tick;
    rst = 1'b0;
    measure_clear("abort", 1'b0);
    read_check("post-abort addr40", 8'd40, 16'h0000, 16'h0000);
    write_word(8'd40, 16'h9999);
    read_check("post-abort write", 8'd40, 16'h9999, 16'h9999);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
